// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Brief    : Shared constants and channel enumeration for the IR guardrail
//            interface (strobe timing for fast-sim and real builds).
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

    // Strobe timing in clocks: full period and emitter-on portion
    localparam int IR_PERIOD_FAST = 64;
    localparam int IR_ON_FAST     = 16;
    localparam int IR_PERIOD_SLOW = 4096;
    localparam int IR_ON_SLOW     = 512;

    localparam int IR_NUM_CH      = 3;
    localparam int IR_SQ_W        = 4;

    // Channel index into the per-channel filter array
    typedef enum logic [1:0] {
        IR_LFT  = 2'd0,
        IR_RGHT = 2'd1,
        IR_CNTR = 2'd2
    } ir_ch_e;

endpackage
`default_nettype wire

// File: rtl/ir_guardrail_intf_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_guardrail_intf_if
// Brief    : Bundle of the cmd_proc-facing controls, raw sensor returns and
//            conditioned sensor outputs of the IR guardrail interface.
// Revision : 1.0 - initial release
// ============================================================================
interface ir_guardrail_intf_if;
    import ir_pkg::*;

    logic               en;
    logic               clr_cnt;
    logic               lftIR_n;
    logic               rghtIR_n;
    logic               cntrIR_n;
    logic               IR_en;
    logic               lftIR;
    logic               rghtIR;
    logic               cntrIR;
    logic               cntr_rise;
    logic [IR_SQ_W-1:0] sq_cnt;

    // Controller / pin side
    modport master (
        output en, clr_cnt, lftIR_n, rghtIR_n, cntrIR_n,
        input  IR_en, lftIR, rghtIR, cntrIR, cntr_rise, sq_cnt
    );

    // Guardrail block side
    modport slave (
        input  en, clr_cnt, lftIR_n, rghtIR_n, cntrIR_n,
        output IR_en, lftIR, rghtIR, cntrIR, cntr_rise, sq_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ir_chan_filter.sv
`default_nettype none
// ============================================================================
// Module   : ir_chan_filter
// Brief    : One sensor channel: 2-flop synchroniser on the active-low return,
//            then a consecutive-sample agree counter that only changes the
//            clean level after FILT_LEN differing strobed samples.
// Revision : 1.0 - initial release
// ============================================================================
module ir_chan_filter #(
    parameter int FILT_LEN = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    input  wire logic strobe,
    input  wire logic in_n,
    output logic      level
);

    localparam int                    c_AGREE_W   = $clog2(FILT_LEN + 1);
    localparam logic [c_AGREE_W-1:0]  c_AGREE_MAX = c_AGREE_W'(FILT_LEN - 1);

    logic [1:0]           r_sync;
    logic                 r_level;
    logic [c_AGREE_W-1:0] r_agree;
    logic                 w_sample;

    // Sample is active high; flops preset inactive so reset exit is quiet
    assign w_sample = ~r_sync[1];

    // Synchroniser runs continuously, independent of the enable clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], in_n};
        end
    end

    // Agree counter and level: a single agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_agree <= '0;
        end else if (clr) begin
            r_level <= 1'b0;
            r_agree <= '0;
        end else if (strobe) begin
            if (w_sample == r_level) begin
                r_agree <= '0;
            end else if (r_agree == c_AGREE_MAX) begin
                r_level <= ~r_level;
                r_agree <= '0;
            end else begin
                r_agree <= r_agree + 1'b1;
            end
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/ir_guardrail_intf.sv
`default_nettype none
// ============================================================================
// Module   : ir_guardrail_intf
// Brief    : Strobes the IR emitter, conditions the three guardrail/centre
//            returns, and counts centre-line crossings for cmd_proc.
// Revision : 1.0 - initial release
// ============================================================================
module ir_guardrail_intf
    import ir_pkg::*;
#(
    parameter int FAST_SIM = 1,
    parameter int FILT_LEN = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ir_guardrail_intf_if.slave bus
);

    localparam int c_PERIOD = (FAST_SIM != 0) ? IR_PERIOD_FAST : IR_PERIOD_SLOW;
    localparam int c_ON     = (FAST_SIM != 0) ? IR_ON_FAST     : IR_ON_SLOW;
    localparam int c_PER_W  = $clog2(c_PERIOD);

    localparam logic [c_PER_W-1:0] c_PER_MAX    = c_PER_W'(c_PERIOD - 1);
    localparam logic [c_PER_W-1:0] c_ON_CNT     = c_PER_W'(c_ON);
    localparam logic [c_PER_W-1:0] c_STROBE_CNT = c_PER_W'(c_ON - 1);
    localparam logic [IR_SQ_W-1:0] c_SQ_MAX     = '1;

    logic [c_PER_W-1:0]   r_per_cnt;
    logic                 r_ir_en;
    logic                 w_strobe;
    logic                 w_clr;
    logic [IR_NUM_CH-1:0] w_in_n;
    logic [IR_NUM_CH-1:0] w_level;
    logic                 r_cntr_d;
    logic                 w_cntr_rise;
    logic [IR_SQ_W-1:0]   r_sq_cnt;

    // Dropping en clears all filter state; the sample is taken at the end of
    // the on-window so the synchronised value reflects a settled return
    assign w_clr    = ~bus.en;
    assign w_strobe = bus.en & (r_per_cnt == c_STROBE_CNT);

    // Strobe period counter and registered emitter enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
            r_ir_en   <= 1'b0;
        end else if (!bus.en) begin
            r_per_cnt <= '0;
            r_ir_en   <= 1'b0;
        end else begin
            r_ir_en   <= (r_per_cnt < c_ON_CNT);
            r_per_cnt <= (r_per_cnt == c_PER_MAX) ? '0 : r_per_cnt + 1'b1;
        end
    end

    assign w_in_n[IR_LFT]  = bus.lftIR_n;
    assign w_in_n[IR_RGHT] = bus.rghtIR_n;
    assign w_in_n[IR_CNTR] = bus.cntrIR_n;

    generate
        for (genvar g = 0; g < IR_NUM_CH; g++) begin : g_chan
            ir_chan_filter #(
                .FILT_LEN (FILT_LEN)
            ) u_filt (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (w_clr),
                .strobe (w_strobe),
                .in_n   (w_in_n[g]),
                .level  (w_level[g])
            );
        end
    endgenerate

    // Previous centre level for edge detection; reset/en-clear only force
    // the level low, so they can never fake a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntr_d <= 1'b0;
        end else begin
            r_cntr_d <= w_level[IR_CNTR];
        end
    end

    assign w_cntr_rise = w_level[IR_CNTR] & ~r_cntr_d;

    // Saturating square counter; clear beats a coincident rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_sq_cnt <= '0;
        end else if (w_cntr_rise && (r_sq_cnt != c_SQ_MAX)) begin
            r_sq_cnt <= r_sq_cnt + 1'b1;
        end
    end

    assign bus.IR_en     = r_ir_en;
    assign bus.lftIR     = w_level[IR_LFT];
    assign bus.rghtIR    = w_level[IR_RGHT];
    assign bus.cntrIR    = w_level[IR_CNTR];
    assign bus.cntr_rise = w_cntr_rise;
    assign bus.sq_cnt    = r_sq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ir_guardrail_intf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_guardrail_intf
// Brief    : Self-checking bench for ir_guardrail_intf (FAST_SIM=1, FILT_LEN=3).
//            Expected square counts are queued as crossings are driven and
//            checked when the block reports each centre rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_guardrail_intf;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         tb_p     = 0;     // expected per_cnt in the current cycle
    logic       exp_ir   = 1'b0;  // expected IR_en in the current cycle
    int         n_strobe = 0;
    logic [3:0] exp_q [$];
    logic [3:0] m_exp;

    ir_guardrail_intf_if bus ();

    ir_guardrail_intf #(
        .FAST_SIM (1),
        .FILT_LEN (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Timing reference: counter 0..63 while en, IR_en = registered (cnt < 16)
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            exp_ir = 1'b0;
            tb_p   = 0;
        end else begin
            if (bus.en && tb_p == 15) n_strobe++;
            exp_ir = bus.en && (tb_p < 16);
            tb_p   = bus.en ? ((tb_p == 63) ? 0 : tb_p + 1) : 0;
        end
        #1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (tb_p != target && guard < 200);
        if (tb_p != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to_timeout: tb_p=%0d required %0d", tb_p, target);
        end
    endtask

    // Set centre return at the start of a window; optionally queue a rise
    task automatic cntr_window(input logic val, input logic push,
                               input logic [3:0] exp_cnt, input logic clr_at_rise);
        run_to(0);
        bus.cntrIR_n = val;
        if (push) exp_q.push_back(exp_cnt);
        if (clr_at_rise) begin
            run_to(16);
            bus.clr_cnt = 1'b1;
            step();
            bus.clr_cnt = 1'b0;
        end
    endtask

    // One clean crossing: 3 windows low then 3 windows high
    task automatic crossing(input logic [3:0] exp_cnt, input logic clr);
        cntr_window(1'b0, 1'b0, 4'd0, 1'b0);
        cntr_window(1'b0, 1'b0, 4'd0, 1'b0);
        cntr_window(1'b0, 1'b1, exp_cnt, clr);
        cntr_window(1'b1, 1'b0, 4'd0, 1'b0);
        cntr_window(1'b1, 1'b0, 4'd0, 1'b0);
        cntr_window(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    // Scoreboard: each rise must be expected, one clk wide, and update sq_cnt
    always @(negedge clk) begin
        if (rst_n && bus.cntr_rise === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cntr_rise_unexpected: pulse at tb_p=%0d, required none", tb_p);
            end else begin
                m_exp = exp_q.pop_front();
                @(posedge clk);
                #1;
                if (bus.sq_cnt !== m_exp) begin
                    n_fail++;
                    $display("FAIL sq_cnt_after_rise: got %0d required %0d", bus.sq_cnt, m_exp);
                end
                n_tests++;
                if (bus.cntr_rise !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cntr_rise_width: got %b required 0 on second clk", bus.cntr_rise);
                end
            end
        end
    end

    task automatic test_reset();
        bus.en = 1'b0; bus.clr_cnt = 1'b0;
        bus.lftIR_n = 1'b1; bus.rghtIR_n = 1'b1; bus.cntrIR_n = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({bus.IR_en, bus.lftIR, bus.rghtIR, bus.cntrIR, bus.cntr_rise, bus.sq_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all 0",
                     {bus.IR_en, bus.lftIR, bus.rghtIR, bus.cntrIR, bus.cntr_rise, bus.sq_cnt});
        end
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int c = 0; c < 140; c++) begin
            step();
            n_tests++;
            if ({bus.IR_en, bus.lftIR, bus.rghtIR, bus.cntrIR, bus.cntr_rise, bus.sq_cnt}
                    !== {exp_ir, 8'd0}) begin
                n_fail++;
                $display("FAIL idle_strobe tb_p=%0d: got %b required %b", tb_p,
                         {bus.IR_en, bus.lftIR, bus.rghtIR, bus.cntrIR, bus.cntr_rise, bus.sq_cnt},
                         {exp_ir, 8'd0});
            end
        end
    endtask

    task automatic test_center_acquire();
        bus.en = 1'b0;
        step();
        step();
        n_strobe     = 0;
        bus.cntrIR_n = 1'b0;
        bus.en       = 1'b1;
        exp_q.push_back(4'd1);
        for (int c = 0; c < 200; c++) begin
            step();
            n_tests++;
            if (bus.cntrIR !== (n_strobe >= 3)) begin
                n_fail++;
                $display("FAIL cntr_acquire c=%0d: got %b required %b", c, bus.cntrIR, (n_strobe >= 3));
            end
        end
        n_tests++;
        if (bus.sq_cnt !== 4'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL cntr_acquire_count: sq_cnt %0d pending %0d required 1 and 0",
                     bus.sq_cnt, exp_q.size());
        end
    endtask

    task automatic test_glitch_reject();
        logic pat [12];
        logic lvl [12];
        logic prev;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        lvl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int w = 0; w < 12; w++) begin
            prev = (w == 0) ? 1'b0 : lvl[w-1];
            run_to(0);
            bus.lftIR_n = pat[w];
            run_to(5);
            n_tests++;
            if (bus.lftIR !== prev) begin
                n_fail++;
                $display("FAIL lft_hold w%0d: got %b required %b", w, bus.lftIR, prev);
            end
            run_to(20);
            n_tests++;
            if (bus.lftIR !== lvl[w]) begin
                n_fail++;
                $display("FAIL lft_filter w%0d: got %b required %b", w, bus.lftIR, lvl[w]);
            end
        end
        bus.lftIR_n = 1'b1;
    endtask

    task automatic test_crossings();
        repeat (3) cntr_window(1'b1, 1'b0, 4'd0, 1'b0);
        run_to(20);
        n_tests++;
        if (bus.cntrIR !== 1'b0) begin
            n_fail++;
            $display("FAIL cntr_release: got %b required 0", bus.cntrIR);
        end
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        n_tests++;
        if (bus.sq_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_cnt: got %0d required 0", bus.sq_cnt);
        end
        for (int k = 1; k <= 6; k++) begin
            crossing(4'(k), 1'b0);
            run_to(20);
            n_tests++;
            if (bus.cntrIR !== 1'b0) begin
                n_fail++;
                $display("FAIL crossing_low k%0d: got %b required 0", k, bus.cntrIR);
            end
        end
        n_tests++;
        if (bus.sq_cnt !== 4'd6) begin
            n_fail++;
            $display("FAIL six_crossings: got %0d required 6", bus.sq_cnt);
        end
        crossing(4'd0, 1'b1);
        run_to(20);
        n_tests++;
        if (bus.sq_cnt !== 4'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clr_beats_rise: sq_cnt %0d pending %0d required 0 and 0",
                     bus.sq_cnt, exp_q.size());
        end
    endtask

    task automatic test_saturation();
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            crossing((k > 15) ? 4'd15 : 4'(k), 1'b0);
        end
        run_to(20);
        n_tests++;
        if (bus.sq_cnt !== 4'd15 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL saturate: sq_cnt %0d pending %0d required 15 and 0",
                     bus.sq_cnt, exp_q.size());
        end
    endtask

    task automatic test_en_drop();
        run_to(0);
        bus.rghtIR_n = 1'b0;
        repeat (3) run_to(20);
        n_tests++;
        if (bus.rghtIR !== 1'b1) begin
            n_fail++;
            $display("FAIL rght_assert: got %b required 1", bus.rghtIR);
        end
        run_to(7);
        bus.en = 1'b0;
        step();
        n_tests++;
        if ({bus.IR_en, bus.rghtIR, bus.cntr_rise} !== 3'b000) begin
            n_fail++;
            $display("FAIL en_drop: IR_en/rghtIR/cntr_rise got %b required 000",
                     {bus.IR_en, bus.rghtIR, bus.cntr_rise});
        end
        repeat (3) step();
        n_tests++;
        if (bus.IR_en !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off_hold: IR_en got %b required 0", bus.IR_en);
        end
        bus.en = 1'b1;
        step();
        n_tests++;
        if (bus.IR_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable_ir: IR_en got %b required 1", bus.IR_en);
        end
        for (int w = 0; w < 3; w++) begin
            run_to(20);
            n_tests++;
            if (bus.rghtIR !== (w == 2)) begin
                n_fail++;
                $display("FAIL rght_refilter w%0d: got %b required %b", w, bus.rghtIR, (w == 2));
            end
        end
        bus.rghtIR_n = 1'b1;
    endtask

    task automatic test_window_ignore();
        run_to(0);
        for (int c = 0; c < 4 * 64; c++) begin
            step();
            if (tb_p == 20) bus.cntrIR_n = 1'b0;
            if (tb_p == 0)  bus.cntrIR_n = 1'b1;
            n_tests++;
            if (bus.cntrIR !== 1'b0) begin
                n_fail++;
                $display("FAIL window_ignore c=%0d: cntrIR got %b required 0", c, bus.cntrIR);
            end
        end
        bus.cntrIR_n = 1'b1;
        step();
        n_tests++;
        if (bus.sq_cnt !== 4'd15 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL window_ignore_count: sq_cnt %0d pending %0d required 15 and 0",
                     bus.sq_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_center_acquire();
        test_glitch_reject();
        test_crossings();
        test_saturation();
        test_en_drop();
        test_window_ignore();
        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
